mic_frame_packer: RTL and testbench

Frames windowed four-microphone samples into fixed-length AXI-Stream frames for the FFT core. Sits between `hanning_window` and `xfft_0`, absorbing the FFT's input backpressure in a small FIFO. It guarantees every frame delivered downstream is exactly `FRAME_LEN` beats with `tlast` on the final beat, even when samples must be dropped.

---
 rtl/mic_frame_packer.sv | 176 +++++++++++++++++
 tb/tb_mic_frame_packer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mic_frame_packer.sv
// Packs strobed four-mic samples into fixed-length AXI-Stream frames through a show-ahead FIFO,
// zero-padding a broken frame after an overflow. Optional drop counter: MIC_FRAME_PACKER_DROP_COUNT_EN.
module mic_frame_packer #(
  parameter int FRAME_LEN  = 512,
  parameter int FIFO_DEPTH = 16,
  parameter int NUM_MICS   = 4
) (
  input  logic                               clk_in,
  input  logic                               rst_in,
  input  logic [NUM_MICS-1:0][15:0]          audio_data_in,
  input  logic                               audio_valid_in,
  output logic [32*NUM_MICS-1:0]             m_axis_tdata,
  output logic                               m_axis_tvalid,
  output logic                               m_axis_tlast,
  input  logic                               m_axis_tready,
  output logic                               overflow_out,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fill_level_out,
  output logic [15:0]                        drop_count_out
);

  localparam int IW = $clog2(FRAME_LEN);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int SW = 16*NUM_MICS;
  localparam int EW = SW+1;
  localparam logic [IW-1:0] IDX_LAST = IW'(FRAME_LEN-1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_PAD = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   wr_idx_q, wr_idx_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic [EW-1:0]   mem_q [FIFO_DEPTH];

  logic            full_s, empty_s, push_s, pop_s, drop_s;
  logic [SW-1:0]   push_data_s;
  logic [EW-1:0]   head_s;

  // Full is judged on pre-pop occupancy, so a push beside a pop at full is still refused.
  assign full_s  = (count_q == CNT_FULL);
  assign empty_s = (count_q == {CW{1'b0}});
  assign pop_s   = !empty_s && m_axis_tready;
  assign head_s  = mem_q[rd_ptr_q];

  // FSM state register
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: an overflow with a partial frame pending pads it out to the frame end.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (audio_valid_in && full_s && (wr_idx_q != {IW{1'b0}})) state_d = ST_PAD;
        else state_d = ST_RUN;
      end
      ST_PAD: begin
        if (!full_s && (wr_idx_q == IDX_LAST)) state_d = ST_RUN;
        else state_d = ST_PAD;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // FSM outputs: what gets pushed and what gets dropped this cycle
  always_comb begin
    push_s      = 1'b0;
    drop_s      = 1'b0;
    push_data_s = {SW{1'b0}};
    case (state_q)
      ST_RUN: begin
        push_s      = audio_valid_in && !full_s;
        drop_s      = audio_valid_in && full_s;
        push_data_s = audio_data_in;
      end
      ST_PAD: begin
        push_s      = !full_s;
        drop_s      = audio_valid_in;
        push_data_s = {SW{1'b0}};
      end
      default: begin
        push_s      = 1'b0;
        drop_s      = 1'b0;
        push_data_s = {SW{1'b0}};
      end
    endcase
  end

  // Next-state for frame index, FIFO pointers and occupancy
  always_comb begin
    wr_idx_d   = wr_idx_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = drop_s;
    if (push_s) begin
      wr_idx_d = wr_idx_q + IW'(1'b1);
      wr_ptr_d = wr_ptr_q + PW'(1'b1);
    end else begin
      wr_idx_d = wr_idx_q;
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) rd_ptr_d = rd_ptr_q + PW'(1'b1);
    else rd_ptr_d = rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1'b1);
      2'b01:   count_d = count_q - CW'(1'b1);
      default: count_d = count_q;
    endcase
  end

  // Control registers
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_idx_q   <= {IW{1'b0}};
      wr_ptr_q   <= {PW{1'b0}};
      rd_ptr_q   <= {PW{1'b0}};
      count_q    <= {CW{1'b0}};
      overflow_q <= 1'b0;
    end else begin
      wr_idx_q   <= wr_idx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is unreset; occupancy alone decides what is visible.
  always_ff @(posedge clk_in) begin
    if (push_s) mem_q[wr_ptr_q] <= {(wr_idx_q == IDX_LAST), push_data_s};
  end

  // Head presentation: real part in the low half of each 32-bit lane, zero while empty
  always_comb begin
    m_axis_tdata = {(32*NUM_MICS){1'b0}};
    for (int k = 0; k < NUM_MICS; k++) begin
      if (!empty_s) m_axis_tdata[32*k +: 32] = {16'h0000, head_s[16*k +: 16]};
      else m_axis_tdata[32*k +: 32] = 32'h0000_0000;
    end
  end

  assign m_axis_tvalid  = !empty_s;
  assign m_axis_tlast   = !empty_s && head_s[SW];
  assign overflow_out   = overflow_q;
  assign fill_level_out = count_q;

`ifdef MIC_FRAME_PACKER_DROP_COUNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // Saturating drop counter
  always_comb begin
    if (drop_s && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
    else drop_cnt_d = drop_cnt_q;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) drop_cnt_q <= 16'h0000;
    else drop_cnt_q <= drop_cnt_d;
  end

  assign drop_count_out = drop_cnt_q;
`else
  assign drop_count_out = 16'h0000;
`endif

endmodule

// File: tb/tb_mic_frame_packer.sv
// Scoreboard bench for mic_frame_packer: stimulus queues expected beats, a negedge monitor checks them.
module tb_mic_frame_packer;
  localparam int NM = 4;
  localparam int FD = 16;
  localparam int CW = $clog2(FD+1);
  localparam int DW = 32*NM;
`ifdef MIC_FRAME_PACKER_DROP_COUNT_EN
  localparam int          N_DROPS  = 70000;
  localparam logic [15:0] EXP_DROP = 16'hFFFF;
`else
  localparam int          N_DROPS  = 40;
  localparam logic [15:0] EXP_DROP = 16'h0000;
`endif

  typedef logic [DW:0] beat_t;

  logic                 clk_in = 1'b0;
  logic                 rst_in = 1'b0;
  logic [NM-1:0][15:0]  audio_data_in = '0;
  logic                 audio_valid_in = 1'b0;
  logic [DW-1:0]        m_axis_tdata;
  logic                 m_axis_tvalid;
  logic                 m_axis_tlast;
  logic                 m_axis_tready = 1'b0;
  logic                 overflow_out;
  logic [CW-1:0]        fill_level_out;
  logic [15:0]          drop_count_out;

  beat_t exp_q[$];
  beat_t mon_e;
  int checks = 0, errors = 0, ovf_cnt = 0, beats = 0, max_fill = 0, ovf0 = 0;

  mic_frame_packer dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .audio_data_in(audio_data_in), .audio_valid_in(audio_valid_in),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .overflow_out(overflow_out), .fill_level_out(fill_level_out),
    .drop_count_out(drop_count_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [NM-1:0][15:0] mk_in(input int base);
    logic [NM-1:0][15:0] r;
    for (int k = 0; k < NM; k++) r[k] = 16'(base + k*1000);
    return r;
  endfunction

  function automatic logic [DW-1:0] mk_data(input int base);
    logic [DW-1:0] d;
    d = '0;
    for (int k = 0; k < NM; k++) d[32*k +: 32] = {16'h0000, 16'(base + k*1000)};
    return d;
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic send(input int base);
    audio_data_in  = mk_in(base);
    audio_valid_in = 1'b1;
    tick();
    audio_valid_in = 1'b0;
  endtask

  task automatic expect_beat(input int base, input bit last);
    exp_q.push_back({last, mk_data(base)});
  endtask

  task automatic expect_zeros(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({(i == n-1), {DW{1'b0}}});
  endtask

  task automatic drain(input int maxc, input string name);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < maxc) begin
      tick();
      c++;
    end
    check(name, longint'(exp_q.size()), 0);
    tick();
    tick();
  endtask

  // Monitor: every accepted beat is popped from the scoreboard and compared
  always @(negedge clk_in) begin
    if (rst_in) begin
      if (overflow_out) ovf_cnt++;
      if (int'(fill_level_out) > max_fill) max_fill = int'(fill_level_out);
      if (m_axis_tvalid && m_axis_tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got last=%b data=%h, required no beat", m_axis_tlast, m_axis_tdata);
        end else begin
          mon_e = exp_q.pop_front();
          beats++;
          if ({m_axis_tlast, m_axis_tdata} !== mon_e) begin
            errors++;
            $display("FAIL beat%0d: got last=%b data=%h, required last=%b data=%h",
                     beats, m_axis_tlast, m_axis_tdata, mon_e[DW], mon_e[DW-1:0]);
          end
        end
      end
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk_in);
    check("rst_tvalid", longint'(m_axis_tvalid), 0);
    check("rst_tlast", longint'(m_axis_tlast), 0);
    check("rst_tdata", longint'(|m_axis_tdata), 0);
    check("rst_fill", longint'(fill_level_out), 0);
    check("rst_ovf", longint'(overflow_out), 0);
    check("rst_drop", longint'(drop_count_out), 0);
    rst_in = 1'b1;
    tick();

    // Streaming: two full frames with sparse input
    m_axis_tready = 1'b1;
    max_fill = 0;
    ovf0 = ovf_cnt;
    for (int i = 0; i < 1024; i++) begin
      expect_beat(i, (i % 512) == 511);
      send(i);
      repeat (3) tick();
    end
    drain(100, "stream_drain");
    check("stream_beats", longint'(beats), 1024);
    check("stream_ovf", longint'(ovf_cnt - ovf0), 0);
    check("stream_maxfill_le1", longint'(max_fill <= 1), 1);

    // Overflow mid-frame: 16 accepted, 17th drops and pads
    m_axis_tready = 1'b0;
    ovf0 = ovf_cnt;
    for (int i = 0; i < 16; i++) begin
      expect_beat(100 + i, 1'b0);
      send(100 + i);
    end
    check("mid_fill16", longint'(fill_level_out), 16);
    send(999);
    for (int i = 0; i < 3; i++) send(777);
    repeat (2) tick();
    check("mid_ovf", longint'(ovf_cnt - ovf0), 4);
    check("mid_fill_hold", longint'(fill_level_out), 16);
    expect_zeros(496);
    m_axis_tready = 1'b1;
    drain(1500, "mid_drain");
    check("mid_fill_end", longint'(fill_level_out), 0);

    // Overflow exactly at frame boundary: no padding may follow
    for (int i = 0; i < 496; i++) begin
      expect_beat(200 + i, 1'b0);
      send(200 + i);
      tick();
    end
    drain(50, "bnd_drain_a");
    m_axis_tready = 1'b0;
    for (int i = 496; i < 512; i++) begin
      expect_beat(200 + i, i == 511);
      send(200 + i);
    end
    check("bnd_fill16", longint'(fill_level_out), 16);
    ovf0 = ovf_cnt;
    send(4321);
    repeat (4) tick();
    check("bnd_ovf", longint'(ovf_cnt - ovf0), 1);
    check("bnd_fill_hold", longint'(fill_level_out), 16);
    m_axis_tready = 1'b1;
    drain(100, "bnd_drain_b");
    repeat (30) tick();
    check("bnd_no_pad", longint'(fill_level_out), 0);

    // Push and pop together while full
    m_axis_tready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      expect_beat(300 + i, 1'b0);
      send(300 + i);
    end
    ovf0 = ovf_cnt;
    audio_data_in  = mk_in(555);
    audio_valid_in = 1'b1;
    m_axis_tready  = 1'b1;
    tick();
    audio_valid_in = 1'b0;
    m_axis_tready  = 1'b0;
    check("pp_fill15", longint'(fill_level_out), 15);
    repeat (3) tick();
    check("pp_ovf", longint'(ovf_cnt - ovf0), 1);
    check("pp_pad_refill", longint'(fill_level_out), 16);

    // Asynchronous reset in the middle of PAD
    #3;
    rst_in = 1'b0;
    #1;
    check("ar_tvalid", longint'(m_axis_tvalid), 0);
    check("ar_tlast", longint'(m_axis_tlast), 0);
    check("ar_fill", longint'(fill_level_out), 0);
    exp_q.delete();
    repeat (2) tick();
    @(negedge clk_in);
    rst_in = 1'b1;
    tick();
    check("ar_drop_clr", longint'(drop_count_out), 0);
    m_axis_tready = 1'b1;
    for (int i = 0; i < 512; i++) begin
      expect_beat(400 + i, i == 511);
      send(400 + i);
      tick();
    end
    drain(50, "ar_drain");

    // Sustained drops for the counter
    m_axis_tready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      expect_beat(600 + i, 1'b0);
      send(600 + i);
    end
    ovf0 = ovf_cnt;
    audio_data_in  = mk_in(11);
    audio_valid_in = 1'b1;
    repeat (N_DROPS) tick();
    audio_valid_in = 1'b0;
    repeat (2) tick();
    check("dc_ovf", longint'(ovf_cnt - ovf0), longint'(N_DROPS));
    check("dc_count", longint'(drop_count_out), longint'(EXP_DROP));
    expect_zeros(496);
    m_axis_tready = 1'b1;
    drain(1500, "dc_drain");
    check("dc_fill_end", longint'(fill_level_out), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
